ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter; the send side of the keyboard link whose receive side is key_driver.

---
 rtl/ps2_host_tx.sv | 159 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter: request-to-send, device-clocked shift-out, ACK check.
// PS2 pins are open-drain; *_oe = 1 pulls the line low.

module ps2_in_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic filt
);
  localparam int FW = $clog2(FILTER_LEN + 1);

  logic          sync1_q, sync2_q, filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  // filt only flips after FILTER_LEN consecutive samples disagree with it
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = sync2_q;
      else                               fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      fcnt_q  <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign filt = filt_q;
endmodule

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int SETUP_CYCLES   = 500,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);
  localparam int CMAX0 = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int CMAX  = (TIMEOUT_CYCLES > CMAX0) ? TIMEOUT_CYCLES : CMAX0;
  localparam int CW    = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SHIFT, S_ACK, S_WAIT_IDLE, S_DONE, S_ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [9:0]    frame_q, frame_d;
  logic          dat_low_q, dat_low_d;
  logic          clk_prev_q;
  logic [1:0]    filt;
  logic          clk_filt, dat_filt, clk_fall, tmo;

  ps2_in_filter #(.FILTER_LEN(FILTER_LEN)) u_filt [1:0] (
    .clock (clock),
    .reset (reset),
    .raw   ({ps2_dat_in, ps2_clk_in}),
    .filt  (filt)
  );

  assign clk_filt = filt[0];
  assign dat_filt = filt[1];
  assign clk_fall = clk_prev_q & ~clk_filt;
  // one counter times inhibit, setup and the inter-edge timeout
  assign tmo      = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitcnt_d  = bitcnt_q;
    frame_d   = frame_q;
    dat_low_d = dat_low_q;
    case (state_q)
      S_IDLE: if (tx_valid) begin
        frame_d = {1'b1, ~^tx_data, tx_data};
        cnt_d   = '0;
        state_d = S_INHIBIT;
      end
      S_INHIBIT: if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
        cnt_d   = '0;
        state_d = S_START;
      end else cnt_d = cnt_q + 1'b1;
      S_START: if (cnt_q == CW'(SETUP_CYCLES - 1)) begin
        cnt_d     = '0;
        bitcnt_d  = '0;
        dat_low_d = 1'b1;
        state_d   = S_SHIFT;
      end else cnt_d = cnt_q + 1'b1;
      S_SHIFT: if (clk_fall) begin
        cnt_d     = '0;
        dat_low_d = ~frame_q[bitcnt_q];
        if (bitcnt_q == 4'd9) state_d = S_ACK;
        else                  bitcnt_d = bitcnt_q + 1'b1;
      end else if (tmo) state_d = S_ERROR;
      else              cnt_d = cnt_q + 1'b1;
      S_ACK: if (clk_fall) begin
        cnt_d   = '0;
        state_d = dat_filt ? S_ERROR : S_WAIT_IDLE;
      end else if (tmo) state_d = S_ERROR;
      else              cnt_d = cnt_q + 1'b1;
      S_WAIT_IDLE: if (clk_filt && dat_filt) state_d = S_DONE;
      else if (clk_fall) cnt_d = '0;
      else if (tmo)      state_d = S_ERROR;
      else               cnt_d = cnt_q + 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bitcnt_q   <= '0;
      frame_q    <= '0;
      dat_low_q  <= 1'b0;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitcnt_q   <= bitcnt_d;
      frame_q    <= frame_d;
      dat_low_q  <= dat_low_d;
      clk_prev_q <= clk_filt;
    end
  end

  assign tx_ready   = (state_q == S_IDLE);
  assign busy       = ~tx_ready;
  assign tx_done    = (state_q == S_DONE);
  assign tx_error   = (state_q == S_ERROR);
  assign ps2_clk_oe = (state_q == S_INHIBIT) || (state_q == S_START);
  assign ps2_dat_oe = (state_q == S_START) || ((state_q == S_SHIFT) && dat_low_q);
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus plus a behavioural PS/2 device that clocks the frame in.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH = 40, SET = 10, TMO = 400, FLT = 4;

  logic       clock = 1'b0, reset;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, busy, tx_done, tx_error;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk, dev_dat;

  int total = 0, bad = 0;
  int cyc = 0, acc_cnt = 0, acc_cyc = 0, done_cnt = 0, done_cyc = 0, err_cnt = 0, err_cyc = 0;
  int coin = 0, busy_bad = 0, inh_run = 0, inh_len = 0, set_run = 0, set_len = 0, rel_cyc = 0;
  logic [1:0] err_oe = 2'b11;
  logic err_prev = 1'b0, rdy_after_err = 1'b0;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .SETUP_CYCLES(SET), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FLT)) dut (
    .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .tx_done(tx_done), .tx_error(tx_error), .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in), .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe));

  // wired-AND bus: either side may pull a line low
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (tx_valid && tx_ready) begin acc_cnt <= acc_cnt + 1; acc_cyc <= cyc; end
    if (tx_done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; if (tx_error) coin <= coin + 1; end
    if (tx_error) begin err_cnt <= err_cnt + 1; err_cyc <= cyc; err_oe <= {ps2_clk_oe, ps2_dat_oe}; end
    if (err_prev) rdy_after_err <= tx_ready;
    err_prev <= tx_error;
    if (busy !== ~tx_ready) busy_bad <= busy_bad + 1;
    if (ps2_clk_oe && !ps2_dat_oe) inh_run <= inh_run + 1;
    else if (inh_run != 0) begin inh_len <= inh_run; inh_run <= 0; end
    if (ps2_clk_oe && ps2_dat_oe) set_run <= set_run + 1;
    else if (set_run != 0) begin set_len <= set_run; set_run <= 0; rel_cyc <= cyc; end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  task automatic host_send(input logic [7:0] b);
    for (int k = 0; k < 100 && !tx_ready; k++) tick();
    tx_valid = 1'b1; tx_data = b;
    tick();
    tx_valid = 1'b0; tx_data = 8'($urandom);
  endtask

  // Device side: waits for request-to-send, generates 11 clocks, samples on rising edges.
  task automatic dev_receive(input int h, input bit do_ack, input int abort_fall, input int glitch_fall,
                             output logic [7:0] got, output logic par, output logic stp);
    int k;
    got = 'x; par = 1'bx; stp = 1'bx;
    for (k = 0; k < 2000 && !(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1); k++) tick();
    if (k == 2000) begin chk("dev_req", 0, 1); return; end
    repeat (h) tick();
    for (int i = 1; i <= 11; i++) begin
      if (i == glitch_fall) begin
        dev_clk = 1'b0; repeat (3) tick(); dev_clk = 1'b1;
        tx_valid = 1'b1; tx_data = 8'h00; tick(); tx_valid = 1'b0;
        repeat (h) tick();
      end
      dev_clk = 1'b0;
      if (i == abort_fall) begin repeat (h / 2) tick(); return; end
      repeat (h) tick();
      if (i <= 8) got[i-1] = ps2_dat_in;
      else if (i == 9) par = ps2_dat_in;
      else if (i == 10) stp = ps2_dat_in;
      dev_clk = 1'b1;
      if (i == 10 && do_ack) dev_dat = 1'b0;
      repeat (h) tick();
    end
    dev_dat = 1'b1;
  endtask

  task automatic wait_end(input int d_prev, input int e_prev, output int res);
    res = 0;
    for (int k = 0; k < 3000; k++) begin
      if (done_cnt != d_prev) begin res = 1; break; end
      if (err_cnt != e_prev)  begin res = 2; break; end
      tick();
    end
  endtask

  task automatic xfer(input string tag, input logic [7:0] b, input int h, input int glitch);
    logic [7:0] got; logic par, stp; int d, e, a, res;
    d = done_cnt; e = err_cnt; a = acc_cnt;
    host_send(b);
    dev_receive(h, 1'b1, 0, glitch, got, par, stp);
    chk({tag, "_data"}, got, b);
    chk({tag, "_par"}, par, odd_par(b));
    chk({tag, "_stop"}, stp, 1'b1);
    wait_end(d, e, res);
    chk({tag, "_end"}, res, 1);
    chk({tag, "_acc"}, acc_cnt - a, 1);
  endtask

  initial begin
    logic [7:0] got; logic par, stp; int d, e, a, res;
    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; dev_clk = 1'b1; dev_dat = 1'b1;
    #1;
    chk("rst_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    chk("rst_pulses", {tx_done, tx_error}, 2'b00);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_ready", {tx_ready, busy}, 2'b10);

    // 0xED with inhibit/setup timing
    d = done_cnt; e = err_cnt;
    host_send(8'hED);
    chk("ed_busy", busy, 1'b1);
    dev_receive(20, 1'b1, 0, 0, got, par, stp);
    chk("ed_frame", {got, par, stp}, {8'hED, 1'b1, 1'b1});
    wait_end(d, e, res);
    chk("ed_end", res, 1);
    chk("ed_inhibit", inh_len, INH);
    chk("ed_setup", set_len, SET);
    chk("ed_noerr", err_cnt - e, 0);

    // back-to-back 0x01 then 0xFF, second request held high throughout the first
    d = done_cnt; e = err_cnt;
    host_send(8'h01);
    tx_valid = 1'b1; tx_data = 8'hFF;
    dev_receive(18, 1'b1, 0, 0, got, par, stp);
    chk("b2b1_frame", {got, par, stp}, {8'h01, 1'b0, 1'b1});
    a = acc_cnt;
    for (int k = 0; k < 200 && acc_cnt == a; k++) tick();
    tx_valid = 1'b0;
    chk("b2b_done1", done_cnt - d, 1);
    chk("b2b_order", acc_cyc > done_cyc, 1);
    d = done_cnt;
    dev_receive(22, 1'b1, 0, 0, got, par, stp);
    chk("b2b2_frame", {got, par, stp}, {8'hFF, 1'b1, 1'b1});
    wait_end(d, e, res);
    chk("b2b2_end", res, 1);

    // no ACK from device
    d = done_cnt; e = err_cnt;
    host_send(8'($urandom));
    dev_receive(20, 1'b0, 0, 0, got, par, stp);
    wait_end(d, e, res);
    chk("nack_end", res, 2);
    repeat (2) tick();
    chk("nack_oe", err_oe, 2'b00);
    chk("nack_ready", rdy_after_err, 1'b1);

    // device never clocks
    d = done_cnt; e = err_cnt;
    host_send(8'($urandom));
    wait_end(d, e, res);
    chk("tmo_end", res, 2);
    chk("tmo_cycles", err_cyc - rel_cyc, TMO);

    // reset mid-frame, then normal byte
    d = done_cnt; e = err_cnt;
    host_send(8'h00);
    dev_receive(20, 1'b1, 4, 0, got, par, stp);
    chk("rst_mid_dat", ps2_dat_oe, 1'b1);
    #2 reset = 1'b1;
    #1 chk("rst_mid_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    dev_clk = 1'b1; dev_dat = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_mid_pulses", (done_cnt - d) + (err_cnt - e), 0);
    xfer("f4", 8'hF4, 20, 0);

    // clock glitch plus stray request during SHIFT
    xfer("glitch", 8'($urandom), 20, 3);

    for (int n = 0; n < 6; n++) xfer("rand", 8'($urandom), int'($urandom_range(15, 30)), 0);

    chk("coincident", coin, 0);
    chk("busy_inv", busy_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
